// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   IF stage and IF/ID pipeline register of the TSC pipelined CPU. Owns the
//   PC, runs the instruction-memory read handshake and loads
//   {inst, pc, pc+1, valid} into IF/ID. Honours hazard stall, branch/jump
//   redirect (flush), and HLT freeze. Counts instructions delivered to IF/ID.
//
// Ports
//   clk, reset_n              clock; synchronous active-low reset
//   i_readM, i_address        instruction read request / address (= pc)
//   i_data, i_ready           returned instruction word / 1-cycle valid pulse
//   stall                     hazard unit hold request
//   redirect_valid/_pc        taken branch/jump: flush IF/ID, retarget pc
//   halt                      HLT decoded: freeze until reset
//   if_id_inst/_pc/_pc_plus1  IF/ID instruction, its address, link value
//   if_id_valid               IF/ID holds a real instruction (0 = bubble)
//   opcode, func_code         decode fields taken straight off if_id_inst
//   num_inst                  instructions loaded into IF/ID (wraps)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                WORD_W   = 16,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              i_readM,
  output logic [WORD_W-1:0] i_address,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_ready,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] if_id_inst,
  output logic [WORD_W-1:0] if_id_pc,
  output logic [WORD_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic [3:0]        opcode,
  output logic [5:0]        func_code,
  output logic [WORD_W-1:0] num_inst
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DROP,
    S_HALT
  } state_t;

  // Modulo-2^WORD_W increment shared by pc, pc+1 and the instruction count.
  function automatic logic [WORD_W-1:0] inc_wrap(input logic [WORD_W-1:0] v);
    return v + WORD_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_p0, pc_d;
  logic [WORD_W-1:0] skid_p0, skid_d;
  logic [WORD_W-1:0] inst_p1, inst_d;
  logic [WORD_W-1:0] pc_p1, pc_p1_d;
  logic [WORD_W-1:0] pc1_p1, pc1_p1_d;
  logic              vld_p1, vld_d;
  logic [WORD_W-1:0] num_q, num_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_p0;
    skid_d   = skid_p0;
    inst_d   = inst_p1;
    pc_p1_d  = pc_p1;
    pc1_p1_d = pc1_p1;
    vld_d    = vld_p1;
    num_d    = num_q;

    if (state_q == S_HALT) begin
      // Frozen: only reset leaves HALT.
    end else if (halt) begin
      state_d = S_HALT;
      vld_d   = 1'b0;
    end else if (redirect_valid) begin
      pc_d  = redirect_pc;
      vld_d = 1'b0;
      case (state_q)
        // A request still in flight must have its response swallowed.
        S_FETCH: state_d = i_ready ? S_FETCH : S_DROP;
        // The squashed response may arrive in the same cycle as a second
        // redirect; once it is seen there is nothing left to wait for.
        S_DROP:  state_d = i_ready ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (i_ready && stall) begin
            // Memory will not replay the word, so park it until stall drops.
            skid_d  = i_data;
            state_d = S_HOLD;
          end else if (i_ready) begin
            inst_d   = i_data;
            pc_p1_d  = pc_p0;
            pc1_p1_d = inc_wrap(pc_p0);
            vld_d    = 1'b1;
            pc_d     = inc_wrap(pc_p0);
            num_d    = inc_wrap(num_q);
          end else if (!stall) begin
            vld_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            inst_d   = skid_p0;
            pc_p1_d  = pc_p0;
            pc1_p1_d = inc_wrap(pc_p0);
            vld_d    = 1'b1;
            pc_d     = inc_wrap(pc_p0);
            num_d    = inc_wrap(num_q);
            state_d  = S_FETCH;
          end
        end
        S_DROP: begin
          if (i_ready) state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- IF (p0) / IF-ID (p1) register boundary ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_p0   <= RESET_PC;
      skid_p0 <= '0;
      inst_p1 <= '0;
      pc_p1   <= '0;
      pc1_p1  <= '0;
      vld_p1  <= 1'b0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_d;
      skid_p0 <= skid_d;
      inst_p1 <= inst_d;
      pc_p1   <= pc_p1_d;
      pc1_p1  <= pc1_p1_d;
      vld_p1  <= vld_d;
      num_q   <= num_d;
    end
  end

  assign i_readM        = (state_q == S_FETCH);
  assign i_address      = pc_p0;
  assign if_id_inst     = inst_p1;
  assign if_id_pc       = pc_p1;
  assign if_id_pc_plus1 = pc1_p1;
  assign if_id_valid    = vld_p1;
  assign opcode         = inst_p1[WORD_W-1 -: 4];
  assign func_code      = inst_p1[5:0];
  assign num_inst       = num_q;

endmodule
